// File: rtl/fft_ctrl_pkg.sv
// ============================================================================
//  Module      : fft_ctrl_pkg
//  Description : Shared definitions for the radix-2 in-place DIT FFT
//                controller: state encoding, default sizing constants and
//                the stage-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_ctrl_pkg;

  // Controller states; explicit 2-bit encoding so the state register is
  // identical in every build.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int C_LOG2N_DEF  = 4;
  localparam int C_BF_LAT_DEF = 2;

  // Width of the stage counter: must hold 0..log2n.
  function automatic int stage_w(input int log2n);
    return $clog2(log2n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// ============================================================================
//  Module      : fft_addr_gen
//  Description : Combinational butterfly address / twiddle generator.
//                For stage s and butterfly k: half = 2**s, pos = k mod half,
//                a = (k div half)*2*half + pos, b = a + half,
//                tw = pos * 2**(LOG2N-1-s).
//  Ports       : k      - butterfly index within the stage (LOG2N-1 bits)
//                stage  - current stage number
//                addr_a - upper-leg read address
//                addr_b - lower-leg read address
//                tw_idx - twiddle ROM index
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N = C_LOG2N_DEF
) (
  input  logic [LOG2N-2:0]           k,
  input  logic [stage_w(LOG2N)-1:0]  stage,
  output logic [LOG2N-1:0]           addr_a,
  output logic [LOG2N-1:0]           addr_b,
  output logic [LOG2N-2:0]           tw_idx
);

  logic [LOG2N-2:0] w_pos_mask;
  logic [LOG2N-2:0] w_pos;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_base;

  always_comb begin
    // pos fits in LOG2N-1 bits because pos < half <= N/2.
    w_pos_mask = ~({(LOG2N-1){1'b1}} << stage);
    w_pos      = k & w_pos_mask;
    w_half     = {{(LOG2N-1){1'b0}}, 1'b1} << stage;
    // Clear the low s bits of k, then move the group number up one place.
    w_base     = ({1'b0, k} >> stage) << (stage + 1'b1);
    addr_a     = w_base | {1'b0, w_pos};
    // Bit s of addr_a is always zero, so OR is the same as adding half.
    addr_b     = addr_a | w_half;
    tw_idx     = w_pos << (LOG2N - 1 - int'(stage));
  end

endmodule

`default_nettype wire

// File: rtl/fft_ctrl.sv
// ============================================================================
//  Module      : fft_ctrl
//  Description : Sequencer for a radix-2 in-place DIT FFT. Issues N/2
//                butterflies per stage over LOG2N stages, waits BF_LAT
//                cycles between stages for write-back, and delays the issue
//                strobe and addresses by BF_LAT cycles to form write strobes.
//  Ports       : clk, rst (async, active-high)
//                start  - request one transform (sampled in IDLE only)
//                hold   - stall butterfly issue
//                busy, done, bf_en, rd_addr_a/b, tw_idx, stage
//                wr_en, wr_addr_a/b - issue signals delayed BF_LAT cycles
//  Options     : FFT_CTRL_INVERSE_EN adds input inverse (latched on start)
//                and output tw_conj.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N  = C_LOG2N_DEF,
  parameter int BF_LAT = C_BF_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       hold,
`ifdef FFT_CTRL_INVERSE_EN
  input  logic                       inverse,
  output logic                       tw_conj,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       bf_en,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_idx,
  output logic [stage_w(LOG2N)-1:0]  stage,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b
);

  localparam int C_SW = stage_w(LOG2N);
  localparam int C_KW = LOG2N - 1;

  state_e                        r_state_q, w_state_d;
  logic [C_KW-1:0]               r_k_q, w_k_d;
  logic [C_SW-1:0]               r_stage_q, w_stage_d;
  logic [2:0]                    r_drain_q, w_drain_d;
  logic [BF_LAT-1:0]             r_wen_q, w_wen_d;
  logic [BF_LAT-1:0][LOG2N-1:0]  r_wa_q, w_wa_d;
  logic [BF_LAT-1:0][LOG2N-1:0]  r_wb_q, w_wb_d;

  logic                          w_run;
  logic                          w_issue;
  logic [LOG2N-1:0]              w_addr_a;
  logic [LOG2N-1:0]              w_addr_b;
  logic [C_KW-1:0]               w_tw;

  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .k      (r_k_q),
    .stage  (r_stage_q),
    .addr_a (w_addr_a),
    .addr_b (w_addr_b),
    .tw_idx (w_tw)
  );

  assign w_run   = (r_state_q == ST_RUN);
  assign w_issue = w_run & ~hold;

  always_comb begin
    w_state_d = r_state_q;
    w_k_d     = r_k_q;
    w_stage_d = r_stage_q;
    w_drain_d = r_drain_q;
    unique case (r_state_q)
      ST_IDLE: begin
        if (start) begin
          w_state_d = ST_RUN;
          w_k_d     = '0;
          w_stage_d = '0;
        end
      end
      ST_RUN: begin
        if (w_issue) begin
          if (r_k_q == {C_KW{1'b1}}) begin
            w_state_d = ST_DRAIN;
            w_k_d     = '0;
            w_drain_d = '0;
          end else begin
            w_k_d = r_k_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Wait out the butterfly latency so the next stage never reads a
        // location that the previous stage has not yet written back.
        if (r_drain_q == 3'(BF_LAT - 1)) begin
          w_drain_d = '0;
          if (r_stage_q == C_SW'(LOG2N - 1)) begin
            w_state_d = ST_DONE;
          end else begin
            w_state_d = ST_RUN;
            w_stage_d = r_stage_q + 1'b1;
          end
        end else begin
          w_drain_d = r_drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase

    // Write delay line advances every cycle, independent of hold.
    w_wen_d    = r_wen_q;
    w_wa_d     = r_wa_q;
    w_wb_d     = r_wb_q;
    w_wen_d[0] = w_issue;
    w_wa_d[0]  = rd_addr_a;
    w_wb_d[0]  = rd_addr_b;
    for (int i = 1; i < BF_LAT; i++) begin
      w_wen_d[i] = r_wen_q[i-1];
      w_wa_d[i]  = r_wa_q[i-1];
      w_wb_d[i]  = r_wb_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= ST_IDLE;
      r_k_q     <= '0;
      r_stage_q <= '0;
      r_drain_q <= '0;
      r_wen_q   <= '0;
      r_wa_q    <= '0;
      r_wb_q    <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_k_q     <= w_k_d;
      r_stage_q <= w_stage_d;
      r_drain_q <= w_drain_d;
      r_wen_q   <= w_wen_d;
      r_wa_q    <= w_wa_d;
      r_wb_q    <= w_wb_d;
    end
  end

`ifdef FFT_CTRL_INVERSE_EN
  logic r_inv_q, w_inv_d;

  always_comb begin
    w_inv_d = r_inv_q;
    if ((r_state_q == ST_IDLE) && start) begin
      w_inv_d = inverse;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inv_q <= 1'b0;
    end else begin
      r_inv_q <= w_inv_d;
    end
  end

  assign tw_conj = r_inv_q;
`endif

  // Read-side outputs are forced to zero outside RUN; during a hold they
  // stay frozen on the pending butterfly.
  assign busy      = w_run | (r_state_q == ST_DRAIN);
  assign done      = (r_state_q == ST_DONE);
  assign bf_en     = w_issue;
  assign rd_addr_a = w_run ? w_addr_a : '0;
  assign rd_addr_b = w_run ? w_addr_b : '0;
  assign tw_idx    = w_run ? w_tw     : '0;
  assign stage     = r_stage_q;
  assign wr_en     = r_wen_q[BF_LAT-1];
  assign wr_addr_a = r_wa_q[BF_LAT-1];
  assign wr_addr_b = r_wb_q[BF_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_fft_ctrl.sv
// ============================================================================
//  Module      : tb_fft_ctrl
//  Description : Directed self-checking bench for fft_ctrl, LOG2N=3, BF_LAT=2.
//                Covers reset state, a plain transform, a stalled transform,
//                a mid-run reset and back-to-back transforms.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       hold;
  logic       busy;
  logic       done;
  logic       bf_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_idx;
  logic [1:0] stage;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;
`ifdef FFT_CTRL_INVERSE_EN
  logic       inverse;
  logic       tw_conj;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed issue order: stage 0, stage 1, stage 2 (4 butterflies each).
  int exp_a [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  // Issue index expected in cycle T+c (-1 = no issue); plain run and
  // run with hold during stage-1 cycles T+9..T+11.
  int map1[24] = '{-1, 0, 1, 2, 3, -1, -1, 4, 5, 6, 7, -1,
                   -1, 8, 9, 10, 11, -1, -1, -1, -1, -1, -1, -1};
  int map2[24] = '{-1, 0, 1, 2, 3, -1, -1, 4, 5, -1, -1, -1,
                   6, 7, -1, -1, 8, 9, 10, 11, -1, -1, -1, -1};

  fft_ctrl #(
    .LOG2N  (3),
    .BF_LAT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
`ifdef FFT_CTRL_INVERSE_EN
    .inverse   (inverse),
    .tw_conj   (tw_conj),
`endif
    .busy      (busy),
    .done      (done),
    .bf_en     (bf_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Move to just after the next rising edge (start of the next cycle).
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input int iss, input int iss_wr, input bit exp_busy, input bit exp_done);
    chk("bf_en", 32'(bf_en), 32'(iss >= 0));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (iss >= 0) begin
      chk("rd_addr_a", 32'(rd_addr_a), exp_a[iss]);
      chk("rd_addr_b", 32'(rd_addr_b), exp_b[iss]);
      chk("tw_idx", 32'(tw_idx), exp_tw[iss]);
      chk("stage", 32'(stage), iss / 4);
    end
    chk("wr_en", 32'(wr_en), 32'(iss_wr >= 0));
    if (iss_wr >= 0) begin
      chk("wr_addr_a", 32'(wr_addr_a), exp_a[iss_wr]);
      chk("wr_addr_b", 32'(wr_addr_b), exp_b[iss_wr]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_bf_en"}, 32'(bf_en), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_rd_addr_a"}, 32'(rd_addr_a), 0);
    chk({tag, "_rd_addr_b"}, 32'(rd_addr_b), 0);
    chk({tag, "_tw_idx"}, 32'(tw_idx), 0);
    chk({tag, "_wr_addr_a"}, 32'(wr_addr_a), 0);
    chk({tag, "_wr_addr_b"}, 32'(wr_addr_b), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
    inverse = 1'b0;
`endif

    // Reset state.
    adv();
    adv();
    @(negedge clk);
    check_all_zero("reset");

    // Plain transform: start sampled in cycle T (first edge after reset).
    adv();
    rst   = 1'b0;
    start = 1'b1;
    adv();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check_cycle(map1[c], (c >= 2) ? map1[c-2] : -1, c <= 18, c == 19);
      adv();
    end

    // Transform with hold high for three cycles at stage 1, k = 2.
    start = 1'b1;
    adv();
    start = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      hold = (c >= 9 && c <= 11);
      @(negedge clk);
      check_cycle(map2[c], (c >= 2) ? map2[c-2] : -1, c <= 21, c == 22);
      if (c == 10) begin
        chk("hold_frozen_a", 32'(rd_addr_a), 4);
        chk("hold_frozen_stage", 32'(stage), 1);
      end
      adv();
    end
    hold = 1'b0;

    // Reset pulse at T+9, restart at T+12, done expected at T+31.
    start = 1'b1;
    adv();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) adv();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    adv();
    rst = 1'b0;
    for (int c = 10; c <= 11; c++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_done", 32'(done), 0);
      adv();
    end
    start = 1'b1;
    adv();
    start = 1'b0;
    for (int c = 13; c <= 32; c++) begin
      @(negedge clk);
      check_cycle(map1[c-12], (c >= 14) ? map1[c-14] : -1, c <= 30, c == 31);
      adv();
    end

    // start held high: one IDLE cycle between done and the next busy.
    start = 1'b1;
    adv();
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      check_cycle((c <= 20) ? map1[c] : 0, (c >= 2) ? map1[c-2] : -1,
                  (c <= 18) || (c == 21), c == 19);
      adv();
    end
    start = 1'b0;
    for (int c = 0; c < 25; c++) adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter LOG2N, default 4, log2 of FFT length N (N = 2**LOG2N, radix-2 in-place DIT).
REQ-002 Parameter BF_LAT, default 2, cycles from butterfly issue (bf_en) to write-back of its results; range 1..7.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request one full transform; sampled only in IDLE.
REQ-006 hold  in  1  stall; suppresses butterfly issue while high.
REQ-007 busy  out  1  high from first RUN cycle through last DRAIN cycle.
REQ-008 done  out  1  one-cycle pulse after final write-back.
REQ-009 bf_en  out  1  drives butterfly adder en; one butterfly issued per high cycle.
REQ-010 rd_addr_a, rd_addr_b  out  LOG2N  read addresses of the butterfly pair, valid when bf_en=1.
REQ-011 tw_idx  out  LOG2N-1  twiddle ROM index, valid when bf_en=1.
REQ-012 stage  out  clog2(LOG2N+1)  current stage number.
REQ-013 wr_en, wr_addr_a, wr_addr_b  out  1, LOG2N, LOG2N  bf_en/rd_addr_a/rd_addr_b delayed exactly BF_LAT cycles.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; encoding from shared package.
REQ-015 IDLE: start=1 -> RUN next cycle, stage=0, butterfly counter k=0; start=0 -> stay.
REQ-016 RUN: bf_en = ~hold; on an issuing cycle k increments; hold=1 freezes k, stage and addresses.
REQ-017 RUN, issuing with k = N/2-1 -> DRAIN next cycle, k cleared.
REQ-018 DRAIN lasts exactly BF_LAT cycles, bf_en=0, hold ignored; then RUN with stage+1, or DONE if stage = LOG2N-1.
REQ-019 DONE lasts one cycle: done=1, busy=0; then IDLE.
REQ-020 Addressing, stage s, butterfly k: half=2**s; pos=k mod half; rd_addr_a = (k div half)*2*half + pos; rd_addr_b = rd_addr_a + half; tw_idx = pos * 2**(LOG2N-1-s).
REQ-021 Addresses, tw_idx are combinational from k/stage; outputs registered only in the write delay line.
REQ-022 start while busy or in DONE ignored; no queuing.
REQ-023 Write delay line shifts every cycle regardless of hold; wr_en never asserted outside a run.
REQ-024 Total cycles start-sampled to done for no-hold run: LOG2N*(N/2 + BF_LAT) + 1.

Reset
REQ-025 rst asserted at any time (incl. mid-RUN/DRAIN) -> IDLE immediately; busy, done, bf_en, wr_en, stage, k, all addresses, delay line = 0.
REQ-026 First start sampled on first rising edge after rst deasserts.

Configuration
REQ-027 Macro FFT_CTRL_INVERSE_EN: when defined, adds input inverse (1 bit, latched on accepted start) and output tw_conj (=latched value, valid with bf_en, reset 0); when undefined neither port exists and the transform is forward only.

Structure
REQ-028 Package fft_ctrl_pkg: state enum, default LOG2N/BF_LAT constants, stage-width function.
REQ-029 Sub-module fft_addr_gen: combinational k/stage -> rd_addr_a, rd_addr_b, tw_idx per REQ-020.

Verification (LOG2N=3, BF_LAT=2)
REQ-030 start pulse at cycle T, hold=0 -> bf_en high T+1..T+4, T+7..T+10, T+13..T+16; done at T+19 only; busy T+1..T+18.
REQ-031 Stage 1 issue sequence (a,b,tw) = (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3); stage 0 = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
REQ-032 wr_en/wr_addr pattern equals bf_en/rd_addr pattern shifted by exactly 2 cycles; last wr_en at T+18.
REQ-033 hold=1 for 3 cycles during stage-1 k=2 -> bf_en low 3 cycles, k=2 reissued with (4,6,0), done delayed to T+22.
REQ-034 rst pulse at T+9 -> all outputs 0 at T+9, no done; new start at T+12 completes normally at T+31.
REQ-035 start held high continuously -> back-to-back transforms, one IDLE cycle between done and next busy.
